jt6295_rom_arb: RTL and testbench

- Shares one external ADPCM ROM port between two jt6295 sound cores, as on boards with a pair of OKI chips fed from a single SDRAM/ROM channel.
- Each core's ROM request (address, cs) is latched and served in round-robin order. Returned bytes are held per requester, with an ok flag per requester.
- Sits between the two jt6295 ROM outputs and the top-level ROM/SDRAM controller.

---
 rtl/jt6295_rom_arb_pkg.sv | 17 +
 rtl/jt6295_rom_arb_if.sv | 16 +
 rtl/jt6295_rom_arb_slot.sv | 46 ++++
 rtl/jt6295_rom_arb.sv | 101 ++++++++++
 tb/tb_jt6295_rom_arb.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jt6295_rom_arb_pkg.sv
// rtl/jt6295_rom_arb_pkg.sv - shared width default, FSM encoding and grant helper for the ROM arbiter
package jt6295_rom_arb_pkg;

  localparam int AW_DEF = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
  function automatic logic next_grant(input logic p0, input logic p1, input logic last);
    return (p0 && p1) ? ~last : p1;
  endfunction

endpackage

// File: rtl/jt6295_rom_arb_if.sv
// rtl/jt6295_rom_arb_if.sv - byte ROM port bundle (address/strobe out, data/ok back)
interface jt6295_rom_arb_if
  import jt6295_rom_arb_pkg::*;
#(
  parameter int AW = AW_DEF
);

  logic [AW-1:0] addr;
  logic          cs;
  logic [7:0]    data;
  logic          ok;

  modport master (output addr, cs, input data, ok);
  modport slave  (input addr, cs, output data, ok);

endinterface

// File: rtl/jt6295_rom_arb_slot.sv
// rtl/jt6295_rom_arb_slot.sv - per-requester request latch, returned byte and ok flag
module jt6295_rom_arb_slot
  import jt6295_rom_arb_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  input  logic          done,
  input  logic [7:0]    rom_data,
  output logic          pend,
  output logic [AW-1:0] req,
  output logic [7:0]    dout,
  output logic          ok
);

  logic          valid;
  logic [AW-1:0] served;
  logic          capture;

  // A held address that was already fetched is served from dout without a new access.
  assign capture = cs && !pend && (!valid || (addr != served));
  assign ok      = valid && !pend && (addr == served);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend   <= 1'b0;
      req    <= '0;
      served <= '0;
      valid  <= 1'b0;
      dout   <= 8'd0;
    end else if (capture) begin
      pend  <= 1'b1;
      req   <= addr;
      valid <= 1'b0;
    end else if (done) begin
      dout   <= rom_data;
      served <= req;
      valid  <= 1'b1;
      pend   <= 1'b0;
    end
  end

endmodule

// File: rtl/jt6295_rom_arb.sv
// rtl/jt6295_rom_arb.sv - round-robin sharing of one ROM port between two jt6295 cores
module jt6295_rom_arb
  import jt6295_rom_arb_pkg::*;
#(
  parameter int   AW       = AW_DEF,
  parameter logic SLOT1_HI = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  jt6295_rom_arb_if.slave  slot0,
  jt6295_rom_arb_if.slave  slot1,
  jt6295_rom_arb_if.master rom
);

  logic          pend0, pend1;
  logic [AW-1:0] req0, req1;
  logic          done0, done1;

  state_t        state, state_nx;
  logic          sel, sel_nx;
  logic          last_grant, last_nx;
  logic          cs_q, cs_nx;
  logic [AW:0]   addr_q, addr_nx;

  assign done0 = (state == WAIT) && rom.ok && !sel;
  assign done1 = (state == WAIT) && rom.ok &&  sel;

  jt6295_rom_arb_slot #(.AW(AW)) u_slot0 (
    .clk      (clk),
    .rst      (rst),
    .addr     (slot0.addr),
    .cs       (slot0.cs),
    .done     (done0),
    .rom_data (rom.data),
    .pend     (pend0),
    .req      (req0),
    .dout     (slot0.data),
    .ok       (slot0.ok)
  );

  jt6295_rom_arb_slot #(.AW(AW)) u_slot1 (
    .clk      (clk),
    .rst      (rst),
    .addr     (slot1.addr),
    .cs       (slot1.cs),
    .done     (done1),
    .rom_data (rom.data),
    .pend     (pend1),
    .req      (req1),
    .dout     (slot1.data),
    .ok       (slot1.ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      cs_q       <= 1'b0;
      addr_q     <= '0;
    end else begin
      state      <= state_nx;
      sel        <= sel_nx;
      last_grant <= last_nx;
      cs_q       <= cs_nx;
      addr_q     <= addr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    last_nx  = last_grant;
    cs_nx    = cs_q;
    addr_nx  = addr_q;
    case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          sel_nx   = next_grant(pend0, pend1, last_grant);
          addr_nx  = sel_nx ? {SLOT1_HI, req1} : {~SLOT1_HI, req0};
          cs_nx    = 1'b1;
          state_nx = ISSUE;
        end
      end
      // rom_ok here still belongs to the previous address, so it is skipped.
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (rom.ok) begin
          last_nx  = sel;
          cs_nx    = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign rom.addr = addr_q;
  assign rom.cs   = cs_q;

endmodule

// File: tb/tb_jt6295_rom_arb.sv
// tb/tb_jt6295_rom_arb.sv - randomized and directed bench for jt6295_rom_arb against a behavioural model
module tb_jt6295_rom_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jt6295_rom_arb_if #(.AW(18)) s0_if ();
  jt6295_rom_arb_if #(.AW(18)) s1_if ();
  jt6295_rom_arb_if #(.AW(19)) rom_if ();

  logic [17:0] a_in [2];
  logic        c_in [2];
  logic        ok_out [2];
  logic [7:0]  dout_out [2];
  logic        rok   = 1'b0;
  logic [7:0]  rdata = 8'd0;

  assign s0_if.addr   = a_in[0];
  assign s0_if.cs     = c_in[0];
  assign s1_if.addr   = a_in[1];
  assign s1_if.cs     = c_in[1];
  assign ok_out[0]    = s0_if.ok;
  assign ok_out[1]    = s1_if.ok;
  assign dout_out[0]  = s0_if.data;
  assign dout_out[1]  = s1_if.data;
  assign rom_if.ok    = rok;
  assign rom_if.data  = rdata;

  jt6295_rom_arb #(.AW(18), .SLOT1_HI(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .slot0 (s0_if),
    .slot1 (s1_if),
    .rom   (rom_if)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rom_fn(input logic [18:0] a);
    logic [7:0] h;
    h = a[7:0] ^ a[15:8] ^ {a[18:16], a[18:16], 2'b01};
    return h + 8'h5A;
  endfunction

  // Behavioural model: pending/served bookkeeping per requester plus a service phase counter.
  bit          armed = 0;
  bit          m_pend [2];
  bit          m_valid [2];
  logic [17:0] m_req [2];
  logic [17:0] m_served [2];
  logic [7:0]  m_dout [2];
  int          m_phase;
  bit          m_who, m_last, m_cs;
  logic [18:0] m_addr;

  task automatic model_step();
    bit cap [2];
    if (rst) begin
      armed = 1;
      for (int i = 0; i < 2; i++) begin
        m_pend[i] = 0; m_valid[i] = 0; m_req[i] = '0; m_served[i] = '0; m_dout[i] = 8'd0;
      end
      m_phase = 0; m_who = 0; m_last = 1; m_cs = 0; m_addr = '0;
      return;
    end
    for (int i = 0; i < 2; i++)
      cap[i] = c_in[i] && !m_pend[i] && (!m_valid[i] || a_in[i] != m_served[i]);
    if (m_phase == 0) begin
      if (m_pend[0] || m_pend[1]) begin
        m_who   = (m_pend[0] && m_pend[1]) ? !m_last : m_pend[1];
        m_addr  = {m_who, m_req[m_who]};
        m_cs    = 1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (rok) begin
      m_dout[m_who]   = rdata;
      m_served[m_who] = m_req[m_who];
      m_valid[m_who]  = 1;
      m_pend[m_who]   = 0;
      m_last          = m_who;
      m_cs            = 0;
      m_phase         = 0;
    end
    for (int i = 0; i < 2; i++)
      if (cap[i]) begin
        m_pend[i] = 1; m_req[i] = a_in[i]; m_valid[i] = 0;
      end
  endtask

  task automatic compare();
    bit exp_ok;
    if (!armed) return;
    chk("rom_cs", rom_if.cs, m_cs);
    chk("rom_addr", rom_if.addr, m_addr);
    for (int i = 0; i < 2; i++) begin
      exp_ok = m_valid[i] && !m_pend[i] && (a_in[i] == m_served[i]);
      chk(i == 0 ? "slot0_ok" : "slot1_ok", ok_out[i], exp_ok);
      if (exp_ok) chk(i == 0 ? "slot0_dout" : "slot1_dout", dout_out[i], m_dout[i]);
      if (ok_out[i])
        chk(i == 0 ? "slot0_rom_byte" : "slot1_rom_byte", dout_out[i],
            rom_fn((i == 1) ? {1'b1, a_in[i]} : {1'b0, a_in[i]}));
    end
  endtask

  // ROM responder: stale ok with wrong data on the first cs cycle, then ok after a delay.
  int          rom_delay  = 0;
  bit          rand_delay = 0;
  bit          force_ok   = 0;
  bit          prev_cs    = 0;
  int          cnt        = 0;
  logic [18:0] grants [$];

  task automatic respond();
    if (rom_if.cs && !prev_cs) grants.push_back(rom_if.addr);
    if (force_ok) begin
      rok = 1'b1; rdata = 8'h5A;
    end else if (rom_if.cs && !prev_cs) begin
      rok = 1'b1; rdata = ~rom_fn(rom_if.addr);
      cnt = rand_delay ? int'($urandom_range(0, 3)) : rom_delay;
    end else if (rom_if.cs) begin
      if (cnt == 0) begin
        rok = 1'b1; rdata = rom_fn(rom_if.addr);
      end else begin
        rok = 1'b0; cnt--;
      end
    end
    prev_cs = rom_if.cs;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    respond();
  endtask

  task automatic wait_ok(input int i, input int bound);
    int n = 0;
    #1;
    while (!ok_out[i] && n < bound) begin
      cycle();
      n++;
    end
    chk(i == 0 ? "wait_slot0_ok" : "wait_slot1_ok", ok_out[i], 1'b1);
  endtask

  int incr [2];
  int n;

  initial begin
    a_in[0] = '0; a_in[1] = '0; c_in[0] = 0; c_in[1] = 0;

    rst = 1'b1;
    cycle(); cycle();
    chk("reset_rom_cs", rom_if.cs, 1'b0);
    chk("reset_slot0_ok", ok_out[0], 1'b0);
    chk("reset_slot1_ok", ok_out[1], 1'b0);
    chk("reset_rom_addr", rom_if.addr, 19'h0);
    rst = 1'b0;

    rom_delay = 0;
    a_in[0] = 18'h00123; c_in[0] = 1;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      if (k == 2) begin
        chk("single_rom_cs", rom_if.cs, 1'b1);
        chk("single_rom_addr", rom_if.addr, 19'h00123);
      end
      if (k == 3) chk("single_ok_early", ok_out[0], 1'b0);
      if (k == 4) begin
        chk("single_ok_latency", ok_out[0], 1'b1);
        chk("single_dout", dout_out[0], rom_fn(19'h00123));
      end
    end
    rom_delay = 2;
    a_in[0] = 18'h00124;
    #1 chk("single_ok_drop", ok_out[0], 1'b0);
    wait_ok(0, 20);
    chk("single_dout2", dout_out[0], rom_fn(19'h00124));

    rst = 1'b1; c_in[0] = 0;
    cycle();
    rst = 1'b0;
    grants.delete();
    rom_delay = 1;
    a_in[0] = 18'h10; a_in[1] = 18'h20; c_in[0] = 1; c_in[1] = 1;
    n = 0;
    #1;
    while (!(ok_out[0] && ok_out[1]) && n < 40) begin cycle(); n++; #1; end
    chk("simul_both_ok", ok_out[0] && ok_out[1], 1'b1);
    chk("simul_grant_count", grants.size(), 2);
    if (grants.size() >= 2) begin
      chk("simul_first", grants[0], 19'h00010);
      chk("simul_second", grants[1], 19'h40020);
    end

    grants.delete();
    incr[0] = 0; incr[1] = 0;
    rand_delay = 1;
    n = 0;
    while (!(incr[0] >= 9 && incr[1] >= 9) && n < 600) begin
      for (int i = 0; i < 2; i++)
        if (ok_out[i]) begin
          a_in[i] = a_in[i] + 18'd1;
          incr[i]++;
        end
      cycle();
      n++;
      #1;
    end
    chk("fair_incr0", incr[0], 9);
    chk("fair_incr1", incr[1], 9);
    chk("fair_grants_ge16", grants.size() >= 16, 1'b1);
    for (int k = 0; k < 16 && k < grants.size(); k++)
      chk("fair_order", grants[k][18], k[0]);
    c_in[0] = 0; c_in[1] = 0;
    rand_delay = 0; rom_delay = 1;
    repeat (20) cycle();

    a_in[1] = 18'h50; c_in[1] = 1;
    wait_ok(1, 30);
    chk("revisit_dout50", dout_out[1], rom_fn(19'h40050));
    a_in[1] = 18'h51;
    #1 chk("revisit_ok_drop", ok_out[1], 1'b0);
    wait_ok(1, 30);
    chk("revisit_dout51", dout_out[1], rom_fn(19'h40051));
    grants.delete();
    a_in[1] = 18'h50;
    #1 chk("revisit_ok_drop2", ok_out[1], 1'b0);
    wait_ok(1, 30);
    chk("revisit_refetch_count", grants.size(), 1);
    if (grants.size() >= 1) chk("revisit_refetch_addr", grants[0], 19'h40050);
    grants.delete();
    repeat (10) cycle();
    chk("hold_no_reissue", grants.size(), 0);

    c_in[1] = 0;
    rom_delay = 3;
    a_in[0] = 18'h00200; c_in[0] = 1;
    n = 0;
    while (!rom_if.cs && n < 10) begin cycle(); n++; end
    chk("midwait_cs_seen", rom_if.cs, 1'b1);
    cycle(); cycle();
    rst = 1'b1; c_in[0] = 0;
    cycle();
    rst = 1'b0; force_ok = 1;
    repeat (3) cycle();
    chk("midwait_rom_cs", rom_if.cs, 1'b0);
    chk("midwait_rom_addr", rom_if.addr, 19'h0);
    chk("midwait_slot0_ok", ok_out[0], 1'b0);
    chk("midwait_slot1_ok", ok_out[1], 1'b0);
    chk("midwait_slot0_dout", dout_out[0], 8'h00);
    chk("midwait_slot1_dout", dout_out[1], 8'h00);
    force_ok = 0;

    rand_delay = 1;
    for (int k = 0; k < 800; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 7) == 0) c_in[i] = ~c_in[i];
        if ($urandom_range(0, 5) == 0) a_in[i] = 18'h100 + 18'($urandom_range(0, 3));
      end
      cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
